// File: rtl/int_writeback_pkg.sv
// Shared integer-writeback types: the architectural register write record
// consumed by the scheduler/regfile and the writeback grant source.
package int_writeback_pkg;

    typedef struct packed {
        logic        valid;
        logic [4:0]  idx;
        logic [31:0] data;
    } int_arch_reg_wb_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_ALU,
        GNT_LSU
    } wb_gnt_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback records holding LSU completions in push order.
// Occupancy is the difference of the wrap-bit pointers.
module wb_fifo
    import int_writeback_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  int_arch_reg_wb_t         i_push_data,
    input  logic                     i_pop,
    output int_arch_reg_wb_t         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    int_arch_reg_wb_t mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (i_push) wr_ptr <= wr_ptr + 1'b1;
            if (i_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n && !i_flush && i_push) mem[wr_ptr[AW-1:0]] <= i_push_data;
    end

    assign o_count = wr_ptr - rd_ptr;
    assign o_full  = (o_count == (AW+1)'(DEPTH));
    assign o_empty = (o_count == '0);
    assign o_head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/int_writeback.sv
// Writeback stage: arbitrates the fixed-latency ALU and the FIFO-buffered LSU
// onto the single integer register write port, with a starvation guard for the LSU.
module int_writeback
    import int_writeback_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  int_arch_reg_wb_t i_alu_wb,
    input  int_arch_reg_wb_t i_lsu_wb,
    output logic             o_lsu_ready,
    output logic             o_alu_stall,
    output int_arch_reg_wb_t o_int_reg_wb,
    input  logic [31:0]      i_log_fd
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    int_arch_reg_wb_t        fifo_head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic [WAIT_W-1:0]       wait_cnt;
    logic                    push;
    logic                    pop;
    logic                    starve;
    wb_gnt_e                 gnt;

    // Ready comes from registered occupancy only, so a same-cycle pop gives no credit.
    assign o_lsu_ready = ~fifo_full;
    assign push        = i_lsu_wb.valid & o_lsu_ready;
    assign pop         = (gnt == GNT_LSU);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_flush     (i_flush),
        .i_push      (push),
        .i_push_data (i_lsu_wb),
        .i_pop       (pop),
        .o_head      (fifo_head),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty),
        .o_count     (fifo_count)
    );

    always_comb begin
        gnt         = GNT_NONE;
        o_alu_stall = 1'b0;
        starve      = ~fifo_empty && (wait_cnt == WAIT_W'(MAX_WAIT));
        if (starve) begin
            gnt         = GNT_LSU;
            o_alu_stall = 1'b1;
        end else if (i_alu_wb.valid) begin
            gnt = GNT_ALU;
        end else if (!fifo_empty) begin
            gnt = GNT_LSU;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            wait_cnt <= '0;
        end else if (pop || fifo_empty) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Writes to x0 are consumed like any other grant but never become visible.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            o_int_reg_wb <= '0;
        end else begin
            case (gnt)
                GNT_ALU: o_int_reg_wb <= '{valid: (i_alu_wb.idx != 5'd0),
                                           idx: i_alu_wb.idx, data: i_alu_wb.data};
                GNT_LSU: o_int_reg_wb <= '{valid: fifo_head.valid && (fifo_head.idx != 5'd0),
                                           idx: fifo_head.idx, data: fifo_head.data};
                default: o_int_reg_wb.valid <= 1'b0;
            endcase
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge i_clk) begin
        if (i_rst_n && !i_flush && i_alu_wb.valid && !fifo_empty && i_alu_wb.idx != 5'd0) begin
            assert (i_alu_wb.idx != fifo_head.idx)
                else $error("[WB ] ALU and LSU head both target x%0d", i_alu_wb.idx);
        end
        if (i_rst_n && i_log_fd != 32'd0) begin
            $display("[WB ] gnt=%s idx=%0d data=%08h count=%0d wait=%0d",
                     gnt.name(), (gnt == GNT_ALU) ? i_alu_wb.idx : fifo_head.idx,
                     (gnt == GNT_ALU) ? i_alu_wb.data : fifo_head.data, fifo_count, wait_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_int_writeback.sv
// Self-checking bench for int_writeback: table of single transactions plus
// hand sequences for starvation/full and flush, with an output scoreboard.
module tb_int_writeback;
    import int_writeback_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             flush;
    int_arch_reg_wb_t alu_wb;
    int_arch_reg_wb_t lsu_wb;
    logic             lsu_ready;
    logic             alu_stall;
    int_arch_reg_wb_t wb_out;
    logic [31:0]      log_fd;

    int n_checks = 0;
    int n_errors = 0;
    int_arch_reg_wb_t exp_q[$];

    int_writeback #(.DEPTH(4), .MAX_WAIT(4)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_flush      (flush),
        .i_alu_wb     (alu_wb),
        .i_lsu_wb     (lsu_wb),
        .o_lsu_ready  (lsu_ready),
        .o_alu_stall  (alu_stall),
        .o_int_reg_wb (wb_out),
        .i_log_fd     (log_fd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_lsu;
        logic [4:0]  idx;
        logic [31:0] data;
        int          lat;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[6];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int_arch_reg_wb_t alu, input int_arch_reg_wb_t lsu, input logic fl);
        alu_wb = alu;
        lsu_wb = lsu;
        flush  = fl;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Every visible writeback must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && wb_out.valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("[TB] FAIL sb_unexpected: got idx=%0d data=%08h expected none", wb_out.idx, wb_out.data);
            end else begin
                int_arch_reg_wb_t e;
                e = exp_q.pop_front();
                if (wb_out !== e) begin
                    n_errors++;
                    $display("[TB] FAIL sb_order: got %0h expected %0h", wb_out, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int a;
        int k;
        logic starve_exp;
        int_arch_reg_wb_t idle;
        idle   = '0;
        log_fd = 32'd0;
        rst_n  = 1'b0;
        applyStimulus(idle, idle, 1'b0);

        vecs[0] = '{1'b0, 5'd5,  32'hDEADBEEF, 1, 1'b1};
        vecs[1] = '{1'b1, 5'd7,  32'h00001234, 2, 1'b1};
        vecs[2] = '{1'b0, 5'd0,  32'hFFFFFFFF, 1, 1'b0};
        vecs[3] = '{1'b1, 5'd0,  32'h00000055, 2, 1'b0};
        vecs[4] = '{1'b0, 5'd31, 32'hA5A5A5A5, 1, 1'b1};
        vecs[5] = '{1'b1, 5'd1,  32'hCAFEF00D, 2, 1'b1};

        // Reset held two cycles
        nextCycle();
        nextCycle();
        rst_n = 1'b1;
        nextCycle();
        checkOutput("reset_valid", 64'(wb_out.valid), 64'd0);
        checkOutput("reset_ready", 64'(lsu_ready), 64'd1);
        checkOutput("reset_stall", 64'(alu_stall), 64'd0);

        // Single-transaction table
        for (int i = 0; i < 6; i++) begin
            int_arch_reg_wb_t rec;
            rec = '{1'b1, vecs[i].idx, vecs[i].data};
            nextCycle();
            if (vecs[i].is_lsu) applyStimulus(idle, rec, 1'b0);
            else                applyStimulus(rec, idle, 1'b0);
            if (vecs[i].exp_valid) exp_q.push_back(rec);
            #1;
            checkOutput($sformatf("v%0d_ready", i), 64'(lsu_ready), 64'd1);
            checkOutput($sformatf("v%0d_stall", i), 64'(alu_stall), 64'd0);
            for (int c = 1; c <= 3; c++) begin
                nextCycle();
                applyStimulus(idle, idle, 1'b0);
                if (c == vecs[i].lat) begin
                    checkOutput($sformatf("v%0d_valid", i), 64'(wb_out.valid), 64'(vecs[i].exp_valid));
                    if (vecs[i].exp_valid)
                        checkOutput($sformatf("v%0d_out", i), 64'(wb_out), 64'(rec));
                end else begin
                    checkOutput($sformatf("v%0d_idle_c%0d", i, c), 64'(wb_out.valid), 64'd0);
                end
                if (vecs[i].is_lsu && c <= 2)
                    checkOutput($sformatf("v%0d_count_c%0d", i, c), 64'(dut.fifo_count), 64'(2 - c));
            end
        end

        // Starvation and full: ALU every cycle, LSU idx 8..11 in cycles 0..3
        a = 0;
        k = 0;
        for (int c = 0; c < 22; c++) begin
            int_arch_reg_wb_t alu_rec;
            int_arch_reg_wb_t lsu_rec;
            nextCycle();
            if (c == 6) checkOutput("starve_lsu8_out", 64'(wb_out), 64'({1'b1, 5'd8, 32'h00001000}));
            if (c == 7) checkOutput("starve_held_alu", 64'(wb_out), 64'({1'b1, 5'd20, 32'hA0000005}));
            alu_rec = '{1'b1, 5'd20, 32'hA0000000 + 32'(a)};
            lsu_rec = (c < 4) ? '{1'b1, 5'(8 + c), 32'h00001000 + 32'(c)} : idle;
            applyStimulus(alu_rec, lsu_rec, 1'b0);
            starve_exp = (c == 5 || c == 10 || c == 15 || c == 20);
            if (starve_exp) begin
                exp_q.push_back('{1'b1, 5'(8 + k), 32'h00001000 + 32'(k)});
                k++;
            end else begin
                exp_q.push_back(alu_rec);
                a++;
            end
            #1;
            checkOutput($sformatf("starve_stall_c%0d", c), 64'(alu_stall), 64'(starve_exp));
            if (c < 4)            checkOutput($sformatf("starve_ready_c%0d", c), 64'(lsu_ready), 64'd1);
            if (c == 4 || c == 5) checkOutput($sformatf("full_ready_c%0d", c), 64'(lsu_ready), 64'd0);
        end
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
            nextCycle();
            applyStimulus(idle, idle, 1'b0);
        end
        nextCycle();
        checkOutput("starve_drained", 64'(exp_q.size()), 64'd0);

        // Flush with 3 queued entries, wait_cnt=2 and a simultaneous LSU push
        for (int c = 0; c < 4; c++) begin
            int_arch_reg_wb_t alu_rec;
            int_arch_reg_wb_t lsu_rec;
            nextCycle();
            alu_rec = '{1'b1, 5'd20, 32'hB0000000 + 32'(c)};
            lsu_rec = '{1'b1, 5'(12 + c), 32'h00002000 + 32'(c)};
            if (c == 3) lsu_rec.idx = 5'd14;
            applyStimulus(alu_rec, lsu_rec, c == 3);
            if (c < 3) exp_q.push_back(alu_rec);
            #1;
            if (c == 3) begin
                checkOutput("preflush_count", 64'(dut.fifo_count), 64'd3);
                checkOutput("preflush_wait", 64'(dut.wait_cnt), 64'd2);
                checkOutput("preflush_stall", 64'(alu_stall), 64'd0);
            end
        end
        nextCycle();
        applyStimulus(idle, idle, 1'b0);
        checkOutput("flush_count", 64'(dut.fifo_count), 64'd0);
        checkOutput("flush_wait", 64'(dut.wait_cnt), 64'd0);
        checkOutput("flush_valid", 64'(wb_out.valid), 64'd0);
        #1;
        checkOutput("flush_ready", 64'(lsu_ready), 64'd1);
        checkOutput("flush_stall", 64'(alu_stall), 64'd0);
        for (int c = 0; c < 6; c++) nextCycle();
        checkOutput("flush_no_writeback", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
